my_universal_register: RTL and testbench
========================================

# my_universal_register

Parametrised multi-mode data register, the next generation of the team's basic clear/load/increment/decrement register. It adds the following on top of the basic set:
- add/subtract of an operand
- single-bit shifts and rotates with serial input
- multi-cycle shift-by-N with a busy/done handshake
- carry/borrow and zero flags
- optional saturating arithmetic

It sits in datapaths as an accumulator, counter or shift register driven by a control unit FSM.

## Interface
- DATA_WIDTH, 8: register width in bits, ≥ 2.
- SATURATE, 0: 0 means INCR/DECR/ADD/SUB wrap modulo 2^DATA_WIDTH; 1 means they clamp at all-ones/zero.
- CNT_W, $clog2(DATA_WIDTH): width of the shift-amount field. Derived; never overridden.
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- ctrl  input  4  operation code, sampled every rising edge.
- data_input  input  DATA_WIDTH  load/add/sub operand. Bits [CNT_W-1:0] give the shift amount n for SHLN/SHRN.
- serial_in  input  1  fill bit for SHL/SHR.
- data_output  output  DATA_WIDTH  register contents.
- carry  output  1  registered carry/borrow/shifted-out bit.
- zero  output  1  combinational, high when data_output == 0.
- busy  output  1  registered, high while a multi-cycle shift is in progress.
- done  output  1  registered, one-cycle pulse when a multi-cycle shift completes.

## Operation
- Ctrl codes:
  - 0 NOP
  - 1 CLR
  - 2 LOAD
  - 3 INCR
  - 4 DECR
  - 5 ADD
  - 6 SUB
  - 7 SHL
  - 8 SHR
  - 9 ROL
  - 10 ROR
  - 11 SHLN
  - 12 SHRN
  - 13–15 reserved, behave as NOP.
- Codes are defined as macros in my_universal_register.vh.
- NOP: register and carry hold.
- CLR: register ← 0, carry ← 0.
- LOAD: register ← data_input, carry ← 0.
- INCR/DECR/ADD/SUB compute at DATA_WIDTH+1 bits.
  - carry ← carry-out for INCR/ADD, borrow for DECR/SUB.
  - Wrap mode: register ← low DATA_WIDTH bits of the result.
  - SATURATE=1: on overflow register ← all-ones; on borrow register ← 0. carry is still set to 1.
- SHL: register ← {reg[W-2:0], serial_in}, carry ← reg[W-1].
- SHR: register ← {serial_in, reg[W-1:1]}, carry ← reg[0].
- ROL/ROR: rotate by one position; carry ← the bit that wrapped around.
- SHLN/SHRN: logical shift by n (zero fill), one bit per cycle, under an FSM with states IDLE and SHIFT.
  - IDLE, command with n ≥ 1: latch n into the down-counter, go to SHIFT, busy ← 1. The register is not modified on this edge.
  - SHIFT, each edge: shift one bit, carry ← bit shifted out, counter − 1. On the edge where the counter goes 1 → 0: go to IDLE, busy ← 0, done ← 1.
  - n = 0: no state change, register and carry hold, done ← 1 on the command edge.
- While busy, every ctrl code except CLR is ignored.
- CLR while busy: register ← 0, carry ← 0, counter ← 0, go to IDLE, busy ← 0, no done pulse.
- done is high for exactly one cycle, then returns to 0.

## Timing
- Reset (rst low, asynchronous): data_output 0, carry 0, busy 0, done 0, state IDLE, counter 0. zero therefore reads 1.
- Reset asserted mid-shift aborts the shift immediately; no done pulse follows.
- Single-cycle ops: result is visible on data_output/carry after the sampling edge. Latency 1.
- SHLN/SHRN with n ≥ 1, command sampled at edge k:
  - busy is high from after edge k until edge k+n.
  - Shifts occur at edges k+1 … k+n.
  - Final value, busy = 0 and done = 1 are visible together after edge k+n.
  - Total latency n+1 cycles.
- A new command can be issued in the cycle done is high; it is sampled at edge k+n+1.
- zero follows data_output combinationally, with no extra latency.

## Test plan
- Wrap/saturate increment: LOAD 0xFF, INCR.
  - SATURATE=0: data 0x00, carry 1, zero 1.
  - SATURATE=1: data 0xFF, carry 1.
- Borrow: LOAD 0x03, SUB with data_input 0x05 → 0xFE, carry 1. Then LOAD 0x00, DECR → 0xFF, carry 1 (SATURATE=1: 0x00, carry 1).
- Single-bit shifts/rotates:
  - LOAD 0x81, SHL with serial_in 1 → 0x03, carry 1.
  - LOAD 0x01, ROR → 0x80, carry 1.
  - LOAD 0x80, SHR with serial_in 0 → 0x40, carry 0.
- Multi-cycle shift: LOAD 0x0F, SHLN n=3, drive INCR on ctrl while busy.
  - busy high for 3 cycles, INCR ignored.
  - Then 0x78, carry 0, one done pulse.
  - SHLN n=0 → done pulse next cycle, data unchanged.
- Abort by CLR: LOAD 0xF0, SHRN n=5, CLR on the second busy cycle → data 0x00, carry 0, busy 0, done never asserts.
- Reset mid-shift: LOAD 0xAA, SHLN n=4, pull rst low between edges during busy → all outputs reset immediately without waiting for clk. After release, NOP cycles keep data 0x00 with busy/done 0.

Source files
------------

// File: rtl/my_universal_register.sv
// Multi-mode data register: clear/load/inc/dec/add/sub, single-bit shifts and
// rotates, and a multi-cycle shift-by-N with busy/done handshake.

`ifndef MY_UNIVERSAL_REGISTER_VH
`define MY_UNIVERSAL_REGISTER_VH
`define MUR_NOP  4'd0
`define MUR_CLR  4'd1
`define MUR_LOAD 4'd2
`define MUR_INCR 4'd3
`define MUR_DECR 4'd4
`define MUR_ADD  4'd5
`define MUR_SUB  4'd6
`define MUR_SHL  4'd7
`define MUR_SHR  4'd8
`define MUR_ROL  4'd9
`define MUR_ROR  4'd10
`define MUR_SHLN 4'd11
`define MUR_SHRN 4'd12
`endif

module my_universal_register #(
  parameter int DATA_WIDTH = 8,
  parameter bit SATURATE   = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            ctrl,
  input  logic [DATA_WIDTH-1:0] data_input,
  input  logic                  serial_in,
  output logic [DATA_WIDTH-1:0] data_output,
  output logic                  carry,
  output logic                  zero,
  output logic                  busy,
  output logic                  done
);

  localparam int CNT_W = $clog2(DATA_WIDTH);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t                state_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  carry_q;
  logic                  done_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  shift_left_q;

  logic [DATA_WIDTH-1:0] operand;
  logic [DATA_WIDTH:0]   wide_sum;
  logic [DATA_WIDTH:0]   wide_diff;
  logic [DATA_WIDTH-1:0] next_data;
  logic                  next_carry;
  logic [CNT_W-1:0]      shift_n;
  logic                  is_shift_n_cmd;

  assign shift_n        = data_input[CNT_W-1:0];
  assign is_shift_n_cmd = (ctrl == `MUR_SHLN) || (ctrl == `MUR_SHRN);

  // Arithmetic at DATA_WIDTH+1 bits; the top bit is carry-out or borrow.
  assign operand   = ((ctrl == `MUR_INCR) || (ctrl == `MUR_DECR))
                     ? DATA_WIDTH'(1) : data_input;
  assign wide_sum  = {1'b0, data_q} + {1'b0, operand};
  assign wide_diff = {1'b0, data_q} - {1'b0, operand};

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    next_data  = data_q;
    next_carry = carry_q;
    case (ctrl)
      `MUR_CLR: begin
        next_data  = '0;
        next_carry = 1'b0;
      end
      `MUR_LOAD: begin
        next_data  = data_input;
        next_carry = 1'b0;
      end
      `MUR_INCR, `MUR_ADD: begin
        next_data  = (SATURATE && wide_sum[DATA_WIDTH]) ? '1 : wide_sum[DATA_WIDTH-1:0];
        next_carry = wide_sum[DATA_WIDTH];
      end
      `MUR_DECR, `MUR_SUB: begin
        next_data  = (SATURATE && wide_diff[DATA_WIDTH]) ? '0 : wide_diff[DATA_WIDTH-1:0];
        next_carry = wide_diff[DATA_WIDTH];
      end
      `MUR_SHL: begin
        next_data  = {data_q[DATA_WIDTH-2:0], serial_in};
        next_carry = data_q[DATA_WIDTH-1];
      end
      `MUR_SHR: begin
        next_data  = {serial_in, data_q[DATA_WIDTH-1:1]};
        next_carry = data_q[0];
      end
      `MUR_ROL: begin
        next_data  = {data_q[DATA_WIDTH-2:0], data_q[DATA_WIDTH-1]};
        next_carry = data_q[DATA_WIDTH-1];
      end
      `MUR_ROR: begin
        next_data  = {data_q[0], data_q[DATA_WIDTH-1:1]};
        next_carry = data_q[0];
      end
      default: begin
        next_data  = data_q;
        next_carry = carry_q;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; the async reset
  // clears every flop, including the shift counter, so an aborted shift leaves nothing behind.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      data_q       <= '0;
      carry_q      <= 1'b0;
      done_q       <= 1'b0;
      cnt_q        <= '0;
      shift_left_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (is_shift_n_cmd) begin
            // The command edge only arms the counter; shifting starts next edge.
            if (shift_n != '0) begin
              state_q      <= SHIFT;
              cnt_q        <= shift_n;
              shift_left_q <= (ctrl == `MUR_SHLN);
            end else begin
              done_q <= 1'b1;
            end
          end else begin
            data_q  <= next_data;
            carry_q <= next_carry;
          end
        end
        SHIFT: begin
          if (ctrl == `MUR_CLR) begin
            state_q <= IDLE;
            data_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
          end else begin
            if (shift_left_q) begin
              data_q  <= {data_q[DATA_WIDTH-2:0], 1'b0};
              carry_q <= data_q[DATA_WIDTH-1];
            end else begin
              data_q  <= {1'b0, data_q[DATA_WIDTH-1:1]};
              carry_q <= data_q[0];
            end
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign data_output = data_q;
  assign carry       = carry_q;
  assign zero        = (data_q == '0);
  assign busy        = (state_q == SHIFT);
  assign done        = done_q;

endmodule

// File: tb/tb_my_universal_register.sv
// Bench for my_universal_register: wrap and saturating instances side by side,
// checked every cycle against an arithmetic model plus directed literal checks.

module tb_my_universal_register;

  localparam int W    = 8;
  localparam int MASK = 255;

  localparam logic [3:0] NOP = 4'd0, CLR = 4'd1, LOAD = 4'd2, INCR = 4'd3,
                         DECR = 4'd4, ADD = 4'd5, SUB = 4'd6, SHL = 4'd7,
                         SHR = 4'd8, ROL = 4'd9, ROR = 4'd10, SHLN = 4'd11,
                         SHRN = 4'd12;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] ctrl;
  logic [7:0] din;
  logic       sin;

  logic [7:0] q_out [2];
  logic       c_out [2];
  logic       z_out [2];
  logic       b_out [2];
  logic       d_out [2];

  int  checks = 0;
  int  errors = 0;
  bit  cmp_en = 1'b0;

  // Model state: instance 0 wraps, instance 1 saturates.
  int  m_data [2];
  int  m_carry[2];
  int  m_busy [2];
  int  m_done [2];
  int  m_orig [2];
  int  m_n    [2];
  int  m_j    [2];
  int  m_left [2];

  my_universal_register #(.DATA_WIDTH(W), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .rst(rst), .ctrl(ctrl), .data_input(din), .serial_in(sin),
    .data_output(q_out[0]), .carry(c_out[0]), .zero(z_out[0]),
    .busy(b_out[0]), .done(d_out[0])
  );

  my_universal_register #(.DATA_WIDTH(W), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .rst(rst), .ctrl(ctrl), .data_input(din), .serial_in(sin),
    .data_output(q_out[1]), .carry(c_out[1]), .zero(z_out[1]),
    .busy(b_out[1]), .done(d_out[1])
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset(input int s);
    m_data[s] = 0; m_carry[s] = 0; m_busy[s] = 0; m_done[s] = 0;
    m_orig[s] = 0; m_n[s] = 0; m_j[s] = 0; m_left[s] = 0;
  endtask

  task automatic model_edge(input int s);
    int r;
    int op;
    bit sat;
    sat = (s == 1);
    m_done[s] = 0;
    if (m_busy[s] != 0) begin
      if (ctrl == CLR) begin
        m_data[s] = 0; m_carry[s] = 0; m_busy[s] = 0;
      end else begin
        // Value after j shifts is the original shifted by j.
        m_j[s]++;
        if (m_left[s] != 0) begin
          m_data[s]  = (m_orig[s] << m_j[s]) & MASK;
          m_carry[s] = (m_orig[s] >> (W - m_j[s])) & 1;
        end else begin
          m_data[s]  = m_orig[s] >> m_j[s];
          m_carry[s] = (m_orig[s] >> (m_j[s] - 1)) & 1;
        end
        if (m_j[s] == m_n[s]) begin
          m_busy[s] = 0; m_done[s] = 1;
        end
      end
    end else begin
      case (ctrl)
        CLR:  begin m_data[s] = 0; m_carry[s] = 0; end
        LOAD: begin m_data[s] = int'(din); m_carry[s] = 0; end
        INCR, ADD: begin
          op = (ctrl == INCR) ? 1 : int'(din);
          r  = m_data[s] + op;
          m_carry[s] = (r > MASK) ? 1 : 0;
          m_data[s]  = (r > MASK && sat) ? MASK : (r & MASK);
        end
        DECR, SUB: begin
          op = (ctrl == DECR) ? 1 : int'(din);
          r  = m_data[s] - op;
          m_carry[s] = (r < 0) ? 1 : 0;
          m_data[s]  = (r < 0 && sat) ? 0 : (r & MASK);
        end
        SHL: begin
          m_carry[s] = (m_data[s] >> 7) & 1;
          m_data[s]  = ((m_data[s] << 1) | int'(sin)) & MASK;
        end
        SHR: begin
          m_carry[s] = m_data[s] & 1;
          m_data[s]  = (m_data[s] >> 1) | (int'(sin) << 7);
        end
        ROL: begin
          m_carry[s] = (m_data[s] >> 7) & 1;
          m_data[s]  = ((m_data[s] << 1) | m_carry[s]) & MASK;
        end
        ROR: begin
          m_carry[s] = m_data[s] & 1;
          m_data[s]  = (m_data[s] >> 1) | (m_carry[s] << 7);
        end
        SHLN, SHRN: begin
          r = int'(din) % W;
          if (r == 0) begin
            m_done[s] = 1;
          end else begin
            m_busy[s] = 1; m_n[s] = r; m_j[s] = 0;
            m_orig[s] = m_data[s]; m_left[s] = (ctrl == SHLN) ? 1 : 0;
          end
        end
        default: ;
      endcase
    end
  endtask

  always @(posedge clk or negedge rst) begin
    for (int s = 0; s < 2; s++) begin
      if (!rst) model_reset(s);
      else      model_edge(s);
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int s = 0; s < 2; s++) begin
        check($sformatf("data%0d", s),  int'(q_out[s]), m_data[s]);
        check($sformatf("carry%0d", s), int'(c_out[s]), m_carry[s]);
        check($sformatf("zero%0d", s),  int'(z_out[s]), (m_data[s] == 0) ? 1 : 0);
        check($sformatf("busy%0d", s),  int'(b_out[s]), m_busy[s]);
        check($sformatf("done%0d", s),  int'(d_out[s]), m_done[s]);
      end
    end
  end

  task automatic step(input logic [3:0] c, input logic [7:0] d, input logic s);
    ctrl = c; din = d; sin = s;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic lit(input string name, input int d0, input int d1, input int c0, input int c1);
    check({name, "_d0"}, int'(q_out[0]), d0);
    check({name, "_d1"}, int'(q_out[1]), d1);
    check({name, "_c0"}, int'(c_out[0]), c0);
    check({name, "_c1"}, int'(c_out[1]), c1);
  endtask

  task automatic lit_reset(input string name);
    for (int s = 0; s < 2; s++) begin
      check($sformatf("%s_d%0d", name, s), int'(q_out[s]), 0);
      check($sformatf("%s_c%0d", name, s), int'(c_out[s]), 0);
      check($sformatf("%s_z%0d", name, s), int'(z_out[s]), 1);
      check($sformatf("%s_b%0d", name, s), int'(b_out[s]), 0);
      check($sformatf("%s_dn%0d", name, s), int'(d_out[s]), 0);
    end
  endtask

  initial begin
    int busy_cnt;
    int done_cnt;
    rst = 1'b0; ctrl = NOP; din = '0; sin = 1'b0;
    repeat (2) @(negedge clk);
    lit_reset("reset");
    rst = 1'b1;
    cmp_en = 1'b1;

    // Wrap vs saturate increment
    step(LOAD, 8'hFF, 1'b0);
    step(INCR, 8'h00, 1'b0);
    lit("incr", 8'h00, 8'hFF, 1, 1);
    check("incr_zero0", int'(z_out[0]), 1);

    // Borrow on SUB and DECR
    step(LOAD, 8'h03, 1'b0);
    step(SUB, 8'h05, 1'b0);
    lit("sub", 8'hFE, 8'h00, 1, 1);
    step(LOAD, 8'h00, 1'b0);
    step(DECR, 8'h00, 1'b0);
    lit("decr", 8'hFF, 8'h00, 1, 1);

    // Single-bit shifts and rotates
    step(LOAD, 8'h81, 1'b0);
    step(SHL, 8'h00, 1'b1);
    lit("shl", 8'h03, 8'h03, 1, 1);
    step(LOAD, 8'h01, 1'b0);
    step(ROR, 8'h00, 1'b0);
    lit("ror", 8'h80, 8'h80, 1, 1);
    step(LOAD, 8'h80, 1'b0);
    step(SHR, 8'h00, 1'b0);
    lit("shr", 8'h40, 8'h40, 0, 0);

    // Shift-by-3 with INCR driven while busy
    step(LOAD, 8'h0F, 1'b0);
    busy_cnt = 0; done_cnt = 0;
    step(SHLN, 8'h03, 1'b0);
    busy_cnt += int'(b_out[0]); done_cnt += int'(d_out[0]);
    for (int i = 0; i < 3; i++) begin
      step(INCR, 8'h00, 1'b0);
      busy_cnt += int'(b_out[0]); done_cnt += int'(d_out[0]);
    end
    check("shln3_busy_cycles", busy_cnt, 3);
    lit("shln3", 8'h78, 8'h78, 0, 0);
    check("shln3_done_now", int'(d_out[0]), 1);
    step(NOP, 8'h00, 1'b0);
    done_cnt += int'(d_out[0]);
    check("shln3_done_pulses", done_cnt, 1);

    // n = 0 (upper data bits ignored): immediate done, data unchanged
    step(SHLN, 8'h08, 1'b0);
    check("shln0_done", int'(d_out[0]), 1);
    check("shln0_busy", int'(b_out[0]), 0);
    lit("shln0", 8'h78, 8'h78, 0, 0);
    step(NOP, 8'h00, 1'b0);
    check("shln0_done_drop", int'(d_out[1]), 0);

    // CLR aborts a shift on the second busy cycle
    step(LOAD, 8'hF0, 1'b0);
    step(SHRN, 8'h05, 1'b0);
    step(NOP, 8'h00, 1'b0);
    step(CLR, 8'h00, 1'b0);
    lit_reset("abort");
    done_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step(NOP, 8'h00, 1'b0);
      done_cnt += int'(d_out[0]) + int'(d_out[1]);
    end
    check("abort_no_done", done_cnt, 0);

    // Asynchronous reset in the middle of a shift
    step(LOAD, 8'hAA, 1'b0);
    ctrl = SHLN; din = 8'h04;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1 lit_reset("async_rst");
    @(negedge clk);
    ctrl = NOP;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) step(NOP, 8'h00, 1'b0);
    lit_reset("post_rst");

    // Randomized traffic, checked every cycle by the compare process
    for (int i = 0; i < 800; i++) begin
      step(4'($urandom_range(0, 15)), 8'($urandom), 1'($urandom_range(0, 1)));
    end

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
